// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the nco frequency-sweep controller: state encoding and
// default widths common to the sweep block, the nco and their benches.
package nco_sweep_pkg;

  localparam int PW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_RUN_UP   = 2'd2,
    ST_RUN_DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell down-counter: a load of N leaves N-1 cycles to run, so o_zero marks the
// last cycle of an N-cycle dwell. A load of 0 behaves like a load of 1.
module nco_dwell_timer
  import nco_sweep_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [DW-1:0] i_val,
  output logic          o_zero
);

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_val == '0) ? '0 : i_val - ONE;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nco_sweep.sv
// Linear frequency-sweep controller feeding the nco phase increment, load strobe
// and clock enable; one-shot up-sweep or continuous triangle until aborted.
module nco_sweep
  import nco_sweep_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_mode,
  input  logic [PW-1:0] i_start_inc,
  input  logic [PW-1:0] i_stop_inc,
  input  logic [PW-1:0] i_step,
  input  logic [DW-1:0] i_dwell,
  output logic [PW-1:0] o_dphase,
  output logic          o_ld,
  output logic          o_ce,
  output logic          o_busy,
  output logic          o_done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_dphase;
  logic [PW-1:0] w_dphase_nxt;
  logic          r_done;
  logic          w_done_nxt;

  logic          r_mode;
  logic [PW-1:0] r_start;
  logic [PW-1:0] r_stop;
  logic [PW-1:0] r_step;
  logic [DW-1:0] r_dwell;

  logic          w_cfg_load;
  logic          w_tmr_load;
  logic [DW-1:0] w_tmr_val;
  logic          w_tmr_en;
  logic          w_zero;
  logic          w_degen;
  logic          w_at_top;
  logic [PW-1:0] w_up;
  logic [PW-1:0] w_dn;

  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] lim);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] sat_sub(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] lim);
    logic [PW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[PW] || (d[PW-1:0] < lim)) ? lim : d[PW-1:0];
  endfunction

  // A zero step or an empty range never leaves the start value.
  assign w_degen  = (r_step == '0) || (r_start >= r_stop);
  assign w_at_top = w_degen || (r_dphase >= r_stop);
  assign w_up     = sat_add(r_dphase, r_step, r_stop);
  assign w_dn     = sat_sub(r_dphase, r_step, r_start);
  assign w_tmr_en = (r_state != ST_IDLE);

  nco_dwell_timer #(.DW(DW)) u_dwell (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_tmr_load),
    .i_en    (w_tmr_en),
    .i_val   (w_tmr_val),
    .o_zero  (w_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_dphase_nxt = r_dphase;
    w_done_nxt   = 1'b0;
    w_cfg_load   = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = r_dwell;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cfg_load   = 1'b1;
          w_state_nxt  = ST_LOAD;
          w_dphase_nxt = i_start_inc;
          w_tmr_load   = 1'b1;
          w_tmr_val    = i_dwell;
        end
      end
      // LOAD is the first cycle of the start dwell, so it shares the up-step rule.
      ST_LOAD, ST_RUN_UP: begin
        w_state_nxt = ST_RUN_UP;
        if (w_zero) begin
          w_tmr_load = 1'b1;
          if (!w_at_top) begin
            w_dphase_nxt = w_up;
          end else if (!r_mode) begin
            w_tmr_load  = 1'b0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (!w_degen) begin
            w_state_nxt  = ST_RUN_DOWN;
            w_dphase_nxt = w_dn;
          end
        end
      end
      ST_RUN_DOWN: begin
        if (w_zero) begin
          w_tmr_load = 1'b1;
          if (r_dphase <= r_start) begin
            w_state_nxt  = ST_RUN_UP;
            w_dphase_nxt = w_up;
          end else begin
            w_dphase_nxt = w_dn;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt  = ST_IDLE;
      w_dphase_nxt = r_dphase;
      w_done_nxt   = 1'b0;
      w_tmr_load   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_dphase <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dphase <= w_dphase_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_cfg_load) begin
      r_mode  <= i_mode;
      r_start <= i_start_inc;
      r_stop  <= i_stop_inc;
      r_step  <= i_step;
      r_dwell <= i_dwell;
    end
  end

  assign o_dphase = r_dphase;
  assign o_ld     = (r_state == ST_LOAD);
  assign o_ce     = (r_state != ST_IDLE);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = r_done;

endmodule

// File: tb/tb_nco_sweep.sv
// Bench for nco_sweep: table of one-shot sweeps, hand-written corner sequences and
// randomized sweeps, all checked cycle by cycle against a plateau-list model.
module tb_nco_sweep;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_abort, i_mode;
  logic [7:0]  i_start_inc, i_stop_inc, i_step;
  logic [15:0] i_dwell;
  logic [7:0]  o_dphase;
  logic        o_ld, o_ce, o_busy, o_done;

  int vectors = 0;
  int miscompares = 0;
  int plat[$];

  always #5 clk = ~clk;

  nco_sweep #(.PW(8), .DW(16)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_mode      (i_mode),
    .i_start_inc (i_start_inc),
    .i_stop_inc  (i_stop_inc),
    .i_step      (i_step),
    .i_dwell     (i_dwell),
    .o_dphase    (o_dphase),
    .o_ld        (o_ld),
    .o_ce        (o_ce),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  typedef struct {
    bit m;
    int s, e, st, dw;
    int exp_busy;
    int exp_last;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (ld,ce,busy,done,dphase packed)", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {20'd0, o_ld, o_ce, o_busy, o_done, o_dphase};
  endfunction

  function automatic logic [31:0] pk(input bit ld, input bit ce, input bit busy,
                                     input bit done, input int d);
    return {20'd0, ld, ce, busy, done, d[7:0]};
  endfunction

  // Model: list of increment plateaus, each held for max(dwell,1) cycles.
  task automatic build_plats(input bit m, input int s, input int e, input int st, input int nmax);
    int v;
    bit up;
    bit degen;
    plat.delete();
    v = s;
    up = 1'b1;
    degen = (st == 0) || (s >= e);
    plat.push_back(v);
    while (plat.size() < nmax) begin
      if (degen) begin
        if (!m) break;
      end else if (up) begin
        if (v == e) begin
          if (!m) break;
          up = 1'b0;
          v = (v - st < s) ? s : v - st;
        end else begin
          v = (v + st > e) ? e : v + st;
        end
      end else begin
        if (v == s) begin
          up = 1'b1;
          v = (v + st > e) ? e : v + st;
        end else begin
          v = (v - st < s) ? s : v - st;
        end
      end
      plat.push_back(v);
    end
  endtask

  task automatic drive_cfg(input bit m, input int s, input int e, input int st, input int dw);
    i_mode      = m;
    i_start_inc = s[7:0];
    i_stop_inc  = e[7:0];
    i_step      = st[7:0];
    i_dwell     = dw[15:0];
  endtask

  // kind: 0 run to done, 1 abort, 2 abort+start same edge, 3 reset; at cycle stop_at-1.
  task automatic run_sweep(input bit m, input int s, input int e, input int st, input int dw,
                           input int kind, input int stop_at, input bit poke,
                           output int nbusy, output int act_last);
    int d_eff, total, exp_d, last;
    d_eff = (dw == 0) ? 1 : dw;
    build_plats(m, s, e, st, (kind == 0) ? 300 : stop_at / d_eff + 2);
    total = (kind == 0) ? plat.size() * d_eff : stop_at;
    drive_cfg(m, s, e, st, dw);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    nbusy = 0;
    last = s;
    for (int k = 0; k < total; k++) begin
      exp_d = plat[k / d_eff];
      last = exp_d;
      nbusy += int'(o_busy);
      chk("trace", obs(), pk(k == 0, 1'b1, 1'b1, 1'b0, exp_d));
      if (poke && k == 1) begin
        drive_cfg(~m, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 9), 1);
        i_start = 1'b1;
      end
      if (kind != 0 && k == total - 1) begin
        if (kind == 3) i_reset = 1'b1;
        else i_abort = 1'b1;
        if (kind == 2) begin
          drive_cfg(1'b0, 3, 9, 3, 1);
          i_start = 1'b1;
        end
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_reset = 1'b0;
    end
    if (kind == 3) last = 0;
    act_last = int'(o_dphase);
    chk("end", obs(), pk(1'b0, 1'b0, 1'b0, kind == 0, last));
    @(posedge clk); #1;
    chk("after_end", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, last));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, la;
    int tri_exp[11];
    tri_exp = '{5, 5, 10, 10, 15, 15, 10, 10, 5, 5, 10};
    tbl[0] = '{m: 1'b0, s: 10,  e: 40,  st: 10,  dw: 3, exp_busy: 12, exp_last: 40};
    tbl[1] = '{m: 1'b0, s: 250, e: 255, st: 4,   dw: 1, exp_busy: 3,  exp_last: 255};
    tbl[2] = '{m: 1'b0, s: 7,   e: 20,  st: 0,   dw: 0, exp_busy: 1,  exp_last: 7};
    tbl[3] = '{m: 1'b0, s: 50,  e: 30,  st: 5,   dw: 2, exp_busy: 2,  exp_last: 50};
    tbl[4] = '{m: 1'b0, s: 0,   e: 255, st: 255, dw: 1, exp_busy: 2,  exp_last: 255};
    tbl[5] = '{m: 1'b0, s: 100, e: 103, st: 2,   dw: 4, exp_busy: 12, exp_last: 103};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    drive_cfg(1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 0));
    i_reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].m, tbl[i].s, tbl[i].e, tbl[i].st, tbl[i].dw, 0, 0, 1'b0, nb, la);
      chk($sformatf("tbl%0d_busy", i), nb, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_last", i), la, tbl[i].exp_last);
    end

    // Triangle by hand, then abort.
    drive_cfg(1'b1, 5, 15, 5, 2);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("tri%0d", k), obs(), pk(k == 0, 1'b1, 1'b1, 1'b0, tri_exp[k]));
      if (k == 10) i_abort = 1'b1;
      @(posedge clk); #1;
    end
    i_abort = 1'b0;
    chk("tri_abort", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 10));

    // Start while busy is ignored; start+abort on the same edge stops.
    run_sweep(1'b0, 10, 40, 10, 3, 0, 0, 1'b1, nb, la);
    chk("poke_last", la, 40);
    run_sweep(1'b1, 20, 80, 15, 2, 2, 9, 1'b1, nb, la);

    // Reset during RUN_DOWN, then a fresh sweep.
    run_sweep(1'b1, 5, 15, 5, 2, 3, 8, 1'b0, nb, la);
    run_sweep(1'b0, 10, 40, 10, 3, 0, 0, 1'b0, nb, la);
    chk("after_reset_busy", nb, 12);

    // Abort in IDLE does not block a start; reset beats start.
    drive_cfg(1'b0, 20, 60, 20, 1);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("idle_abort_start", obs(), pk(1'b1, 1'b1, 1'b1, 1'b0, 20));
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("busy_abort", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 20));
    i_reset = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_start = 1'b0;
    chk("reset_beats_start", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 0));

    for (int n = 0; n < 40; n++) begin
      bit m;
      int s, e, st, dw, r, kind;
      m  = 1'($urandom_range(0, 1));
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      r  = $urandom_range(0, 9);
      st = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 40);
      dw = $urandom_range(0, 4);
      kind = m ? $urandom_range(1, 3) : 0;
      run_sweep(m, s, e, st, dw, kind, $urandom_range(1, 60), 1'($urandom_range(0, 1)), nb, la);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
